// File: rtl/dt_pkg.sv
// rtl/dt_pkg.sv - shared constants, scan FSM states and bin mapping for the DT result stage
//
// Purpose: image geometry, datapath widths, histogram geometry and the
//          result-scan state encoding used by dt_result_scan and dt_hist_bank.
// Ports:   none (package).
package dt_pkg;

   localparam int IMG_W  = 128;
   localparam int IMG_H  = 128;
   localparam int ADDR_W = 14;
   localparam int DW     = 8;
   localparam int NBINS  = 16;
   localparam int CW     = 15;
   localparam int NPIX   = IMG_W * IMG_H;
   localparam int BIN_W  = $clog2(NBINS);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SCAN  = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } dt_state_e;

   // Distances at or above the last bin index all land in the last bin.
   function automatic logic [BIN_W-1:0] dist_to_bin(input logic [DW-1:0] d);
      if (d >= DW'(NBINS - 1)) begin
         return BIN_W'(NBINS - 1);
      end
      return d[BIN_W-1:0];
   endfunction

endpackage

// File: rtl/dt_hist_bank.sv
// rtl/dt_hist_bank.sv - NBINS x CW histogram counter bank with clear, increment and registered read
//
// Purpose: holds the distance histogram. One bin may be incremented per
//          cycle; a synchronous clear zeroes every bin; the read port is
//          registered every cycle.
// Ports:
//   i_clk      clock
//   i_reset    synchronous active-high reset (bins and read register to 0)
//   i_clr      synchronous clear of all bins (wins over i_inc)
//   i_inc      increment bin i_inc_bin this cycle
//   i_inc_bin  bin to increment
//   i_rd_sel   bin to read
//   o_rd_cnt   registered count of bin i_rd_sel (one-cycle latency)
module dt_hist_bank
   import dt_pkg::*;
(
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_clr,
   input  logic             i_inc,
   input  logic [BIN_W-1:0] i_inc_bin,
   input  logic [BIN_W-1:0] i_rd_sel,
   output logic [CW-1:0]    o_rd_cnt
);

   logic [CW-1:0] r_bins [NBINS];
   logic [CW-1:0] r_rd_cnt;

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         for (int i = 0; i < NBINS; i++) begin
            r_bins[i] <= '0;
         end
         r_rd_cnt <= '0;
      end else begin
         if (i_clr) begin
            for (int i = 0; i < NBINS; i++) begin
               r_bins[i] <= '0;
            end
         end else if (i_inc) begin
            r_bins[i_inc_bin] <= r_bins[i_inc_bin] + CW'(1);
         end
         r_rd_cnt <= r_bins[i_rd_sel];
      end
   end

   assign o_rd_cnt = r_rd_cnt;

endmodule

// File: rtl/dt_result_scan.sv
// rtl/dt_result_scan.sv - reads the finished DT map and reports max, object count and histogram
//
// Purpose: on a rising edge of i_dt_done, streams addresses 0..NPIX-1 to the
//          res memory, accumulates max distance (lowest address on ties),
//          non-zero pixel count and a saturating 16-bin histogram.
// Ports:
//   i_clk        clock
//   i_reset      synchronous active-high reset
//   i_dt_done    DT engine done level; rising edge starts a scan when idle
//   o_res_rd     res read enable (registered)
//   o_res_addr   res read address (registered, holds when o_res_rd = 0)
//   i_res_di     res read data, valid one cycle after address
//   o_busy       scan in progress
//   o_scan_done  results valid; held until the next scan starts
//   o_max_dist   largest distance
//   o_max_addr   lowest address holding o_max_dist
//   o_obj_count  number of non-zero pixels
//   i_hist_sel   histogram bin select
//   o_hist_cnt   registered count of bin i_hist_sel
module dt_result_scan
   import dt_pkg::*;
(
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic              i_dt_done,
   output logic              o_res_rd,
   output logic [ADDR_W-1:0] o_res_addr,
   input  logic [DW-1:0]     i_res_di,
   output logic              o_busy,
   output logic              o_scan_done,
   output logic [DW-1:0]     o_max_dist,
   output logic [ADDR_W-1:0] o_max_addr,
   output logic [CW-1:0]     o_obj_count,
   input  logic [BIN_W-1:0]  i_hist_sel,
   output logic [CW-1:0]     o_hist_cnt
);

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NPIX - 1);

   dt_state_e         r_state;
   dt_state_e         w_state_nxt;
   logic              r_dt_done_q;
   logic              w_start;
   logic              w_scan_start;

   logic              r_res_rd;
   logic [ADDR_W-1:0] r_res_addr;
   logic              r_busy;
   logic              r_scan_done;

   // Read request delayed by one cycle so it lines up with i_res_di.
   logic              r_vld;
   logic [ADDR_W-1:0] r_vaddr;

   logic [DW-1:0]     r_max_dist;
   logic [ADDR_W-1:0] r_max_addr;
   logic [CW-1:0]     r_obj_count;

   assign w_start      = i_dt_done & ~r_dt_done_q;
   // Edges seen outside IDLE are dropped, so a scan never restarts midway.
   assign w_scan_start = (r_state == IDLE) && w_start;

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (w_start) w_state_nxt = SCAN;
         SCAN:    if (r_res_addr == LAST_ADDR) w_state_nxt = DRAIN;
         DRAIN:   w_state_nxt = DONE;
         DONE:    w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state     <= IDLE;
         r_dt_done_q <= 1'b0;
         r_res_rd    <= 1'b0;
         r_res_addr  <= '0;
         r_busy      <= 1'b0;
         r_scan_done <= 1'b0;
         r_vld       <= 1'b0;
         r_vaddr     <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_dt_done_q <= i_dt_done;
         r_vld       <= r_res_rd;
         r_vaddr     <= r_res_addr;
         case (r_state)
            IDLE: begin
               if (w_start) begin
                  r_res_rd    <= 1'b1;
                  r_res_addr  <= '0;
                  r_busy      <= 1'b1;
                  r_scan_done <= 1'b0;
               end
            end
            SCAN: begin
               if (r_res_addr == LAST_ADDR) begin
                  r_res_rd <= 1'b0;
               end else begin
                  r_res_addr <= r_res_addr + ADDR_W'(1);
               end
            end
            DRAIN: begin
               // Last datum is accumulated on this same edge.
               r_busy      <= 1'b0;
               r_scan_done <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset || w_scan_start) begin
         r_max_dist  <= '0;
         r_max_addr  <= '0;
         r_obj_count <= '0;
      end else if (r_vld) begin
         if (i_res_di != '0) begin
            r_obj_count <= r_obj_count + CW'(1);
         end
         // Strict compare keeps the lowest address on ties.
         if (i_res_di > r_max_dist) begin
            r_max_dist <= i_res_di;
            r_max_addr <= r_vaddr;
         end
      end
   end

   dt_hist_bank u_hist (
      .i_clk     (i_clk),
      .i_reset   (i_reset),
      .i_clr     (w_scan_start),
      .i_inc     (r_vld),
      .i_inc_bin (dist_to_bin(i_res_di)),
      .i_rd_sel  (i_hist_sel),
      .o_rd_cnt  (o_hist_cnt)
   );

   assign o_res_rd    = r_res_rd;
   assign o_res_addr  = r_res_addr;
   assign o_busy      = r_busy;
   assign o_scan_done = r_scan_done;
   assign o_max_dist  = r_max_dist;
   assign o_max_addr  = r_max_addr;
   assign o_obj_count = r_obj_count;

endmodule

// File: tb/tb_dt_result_scan.sv
// tb/tb_dt_result_scan.sv - directed self-checking bench for dt_result_scan
module tb_dt_result_scan;
   import dt_pkg::*;

   localparam int SCAN_LAT = 16386;

   logic              clk;
   logic              reset;
   logic              dt_done;
   logic              res_rd;
   logic [ADDR_W-1:0] res_addr;
   logic [DW-1:0]     res_di;
   logic              busy;
   logic              scan_done;
   logic [DW-1:0]     max_dist;
   logic [ADDR_W-1:0] max_addr;
   logic [CW-1:0]     obj_count;
   logic [BIN_W-1:0]  hist_sel;
   logic [CW-1:0]     hist_cnt;

   logic [DW-1:0]     mem [NPIX];

   int checks = 0;
   int errors = 0;

   dt_result_scan dut (
      .i_clk       (clk),
      .i_reset     (reset),
      .i_dt_done   (dt_done),
      .o_res_rd    (res_rd),
      .o_res_addr  (res_addr),
      .i_res_di    (res_di),
      .o_busy      (busy),
      .o_scan_done (scan_done),
      .o_max_dist  (max_dist),
      .o_max_addr  (max_addr),
      .o_obj_count (obj_count),
      .i_hist_sel  (hist_sel),
      .o_hist_cnt  (hist_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // res memory model: one-cycle read latency
   always @(posedge clk) begin
      if (res_rd) res_di <= mem[res_addr];
   end

   task automatic clear_map();
      for (int a = 0; a < NPIX; a++) mem[a] = '0;
   endtask

   task automatic read_bin(input int sel, output int val);
      @(negedge clk);
      hist_sel = BIN_W'(sel);
      @(negedge clk);
      val = int'(hist_cnt);
   endtask

   // Pulses dt_done, follows the scan cycle by cycle and returns the cycle
   // (relative to the start edge) at which scan_done was first seen high.
   task automatic run_scan(input int abort_at, input int glitch_at,
                           output int lat, output int mon_bad);
      lat = -1;
      mon_bad = 0;
      @(negedge clk);
      dt_done = 1'b1;
      @(posedge clk);
      for (int k = 1; k <= 20000; k++) begin
         @(negedge clk);
         if (k == 2) dt_done = 1'b0;
         if (glitch_at > 0 && k == glitch_at) dt_done = 1'b1;
         if (glitch_at > 0 && k == glitch_at + 2) dt_done = 1'b0;
         if (k <= NPIX && (res_rd !== 1'b1 || res_addr !== ADDR_W'(k - 1))) mon_bad++;
         if (k == NPIX + 1 && res_rd !== 1'b0) mon_bad++;
         if (abort_at > 0 && k == abort_at) begin
            reset = 1'b1;
            lat = k;
            break;
         end
         if (scan_done === 1'b1) begin
            lat = k;
            break;
         end
      end
   endtask

   task automatic test_reset();
      int v;
      reset = 1'b1;
      dt_done = 1'b0;
      hist_sel = '0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      checks++;
      if (res_rd !== 1'b0 || busy !== 1'b0 || scan_done !== 1'b0) begin
         errors++;
         $display("FAIL reset_ctrl: rd=%0b busy=%0b done=%0b, expected 0 0 0", res_rd, busy, scan_done);
      end
      checks++;
      if (max_dist !== '0 || max_addr !== '0 || obj_count !== '0 || res_addr !== '0 || hist_cnt !== '0) begin
         errors++;
         $display("FAIL reset_results: max=%0d addr=%0d obj=%0d raddr=%0d hist=%0d, expected all 0",
                  max_dist, max_addr, obj_count, res_addr, hist_cnt);
      end
      read_bin(7, v);
      checks++;
      if (v != 0) begin
         errors++;
         $display("FAIL reset_bin7: got %0d expected 0", v);
      end
   endtask

   task automatic test_ramp_scan();
      int lat, mb, v, exp_v;
      for (int a = 0; a < NPIX; a++) mem[a] = DW'(a % 256);
      run_scan(0, 0, lat, mb);
      checks++;
      if (lat != SCAN_LAT) begin
         errors++;
         $display("FAIL ramp_latency: got %0d expected %0d", lat, SCAN_LAT);
      end
      checks++;
      if (max_dist !== 8'd255 || max_addr !== 14'd255 || obj_count !== 15'd16320) begin
         errors++;
         $display("FAIL ramp_results: max=%0d addr=%0d obj=%0d, expected 255 255 16320",
                  max_dist, max_addr, obj_count);
      end
      for (int b = 0; b < NBINS; b++) begin
         exp_v = (b < NBINS - 1) ? 64 : 15424;
         read_bin(b, v);
         checks++;
         if (v != exp_v) begin
            errors++;
            $display("FAIL ramp_bin%0d: got %0d expected %0d", b, v, exp_v);
         end
      end
   endtask

   task automatic test_back_to_back();
      int lat, mb, v;
      clear_map();
      run_scan(0, 0, lat, mb);
      checks++;
      if (lat != SCAN_LAT) begin
         errors++;
         $display("FAIL zero_latency: got %0d expected %0d", lat, SCAN_LAT);
      end
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL zero_busy: got %0b expected 0", busy);
      end
      checks++;
      if (max_dist !== '0 || max_addr !== '0 || obj_count !== '0) begin
         errors++;
         $display("FAIL zero_results: max=%0d addr=%0d obj=%0d, expected 0 0 0",
                  max_dist, max_addr, obj_count);
      end
      read_bin(0, v);
      checks++;
      if (v != 16384) begin
         errors++;
         $display("FAIL zero_bin0: got %0d expected 16384", v);
      end
      for (int b = 1; b < NBINS; b++) begin
         read_bin(b, v);
         checks++;
         if (v != 0) begin
            errors++;
            $display("FAIL zero_bin%0d: got %0d expected 0", b, v);
         end
      end
   endtask

   task automatic test_addr_monitor();
      int lat, mb, v;
      clear_map();
      mem[500]   = 8'd7;
      mem[9000]  = 8'd7;
      mem[12000] = 8'd200;
      // addr 5000 is on the bus in cycle T+5001: re-raise dt_done there
      run_scan(0, 5001, lat, mb);
      checks++;
      if (mb != 0) begin
         errors++;
         $display("FAIL addr_sequence: %0d bad cycles, expected 0", mb);
      end
      checks++;
      if (lat != SCAN_LAT) begin
         errors++;
         $display("FAIL three_latency: got %0d expected %0d", lat, SCAN_LAT);
      end
      checks++;
      if (max_dist !== 8'd200 || max_addr !== 14'd12000 || obj_count !== 15'd3) begin
         errors++;
         $display("FAIL three_results: max=%0d addr=%0d obj=%0d, expected 200 12000 3",
                  max_dist, max_addr, obj_count);
      end
      read_bin(7, v);
      checks++;
      if (v != 2) begin
         errors++;
         $display("FAIL three_bin7: got %0d expected 2", v);
      end
      read_bin(15, v);
      checks++;
      if (v != 1) begin
         errors++;
         $display("FAIL three_bin15: got %0d expected 1", v);
      end
      read_bin(0, v);
      checks++;
      if (v != 16381) begin
         errors++;
         $display("FAIL three_bin0: got %0d expected 16381", v);
      end
   endtask

   task automatic test_reset_mid_scan();
      int lat, mb, v;
      clear_map();
      mem[129] = 8'd1;
      run_scan(8001, 0, lat, mb);
      checks++;
      if (lat != 8001) begin
         errors++;
         $display("FAIL abort_reach: scan stopped at cycle %0d expected 8001", lat);
      end
      @(negedge clk);
      reset = 1'b0;
      checks++;
      if (res_rd !== 1'b0 || busy !== 1'b0 || scan_done !== 1'b0) begin
         errors++;
         $display("FAIL abort_ctrl: rd=%0b busy=%0b done=%0b, expected 0 0 0", res_rd, busy, scan_done);
      end
      checks++;
      if (max_dist !== '0 || max_addr !== '0 || obj_count !== '0 || hist_cnt !== '0) begin
         errors++;
         $display("FAIL abort_results: max=%0d addr=%0d obj=%0d hist=%0d, expected all 0",
                  max_dist, max_addr, obj_count, hist_cnt);
      end
      repeat (2) @(negedge clk);
      run_scan(0, 0, lat, mb);
      checks++;
      if (lat != SCAN_LAT || mb != 0) begin
         errors++;
         $display("FAIL rescan_timing: lat=%0d bad=%0d, expected %0d 0", lat, mb, SCAN_LAT);
      end
      checks++;
      if (max_dist !== 8'd1 || max_addr !== 14'd129 || obj_count !== 15'd1) begin
         errors++;
         $display("FAIL single_results: max=%0d addr=%0d obj=%0d, expected 1 129 1",
                  max_dist, max_addr, obj_count);
      end
      read_bin(1, v);
      checks++;
      if (v != 1) begin
         errors++;
         $display("FAIL single_bin1: got %0d expected 1", v);
      end
      read_bin(0, v);
      checks++;
      if (v != 16383) begin
         errors++;
         $display("FAIL single_bin0: got %0d expected 16383", v);
      end
   endtask

   initial begin
      res_di = '0;
      clear_map();
      test_reset();
      test_ramp_scan();
      test_back_to_back();
      test_addr_monitor();
      test_reset_mid_scan();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
